sd_reader: RTL

SD_READER -- requirements
Module: sd_reader

---
 rtl/sd_reader.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/sd_reader.sv
// SPI-mode SD card reader: fetches i_block_count consecutive 512-byte blocks with CMD17
// and streams each received byte to a downstream FIFO.
module sd_reader #(
   parameter logic [31:0] START_ADDRESS = 32'h00F0_0000,
   parameter int unsigned R1_TIMEOUT    = 80,
   parameter int unsigned MAX_RETRY     = 4,
   parameter int unsigned TOKEN_TIMEOUT = 4096
) (
   input  logic        i_s_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [7:0]  i_block_count,
   input  logic [10:0] i_fifo_free_count,
   input  logic        MISO,
   output logic        MOSI,
   output logic        o_fifo_push,
   output logic [7:0]  o_8_fifo_data_in,
   output logic        o_busy,
   output logic        o_error,
   output logic [7:0]  o_8_LED
);

   typedef enum logic [4:0] {
      sIdle       = 5'd0,
      sCheckCount = 5'd1,
      sSendCMD17  = 5'd2,
      sWaitR1     = 5'd3,
      sWaitToken  = 5'd4,
      sRecvData   = 5'd5,
      sRecvCRC    = 5'd6,
      sNextBlock  = 5'd7,
      sFINAL      = 5'd8,
      sERROR      = 5'd9
   } state_t;

   localparam logic [15:0] R1_LAST    = 16'(R1_TIMEOUT - 32'd1);
   localparam logic [15:0] TOKEN_LAST = 16'(TOKEN_TIMEOUT - 32'd1);
   localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRY);

   state_t       state_q, state_d;
   logic [31:0]  addr_q, addr_d;
   logic [7:0]   blocks_q, blocks_d;
   logic [7:0]   retry_q, retry_d;
   logic [15:0]  cnt_q, cnt_d;
   logic [47:0]  cmd_q, cmd_d;
   logic [7:0]   shreg_q, shreg_d;
   logic         r1_active_q, r1_active_d;
   logic         mosi_q, mosi_d;
   logic         push_q, push_d;
   logic [7:0]   data_q, data_d;
   logic         busy_q, busy_d;
   logic         error_q, error_d;
   logic [7:0]   led_q, led_d;
   logic [47:0]  cmd_frame;

   assign cmd_frame = {8'h51, addr_q, 8'hFF};

   // Next-state and next-output computation for the read sequencer.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      blocks_d    = blocks_q;
      retry_d     = retry_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      shreg_d     = shreg_q;
      r1_active_d = r1_active_q;
      push_d      = 1'b0;
      data_d      = data_q;

      case (state_q)
         sIdle: begin
            if (i_start) state_d = sCheckCount;
            else         state_d = sIdle;
         end
         sCheckCount: begin
            if (blocks_q == i_block_count) begin
               state_d = sFINAL;
            end else if (i_fifo_free_count >= 11'd512) begin
               state_d = sSendCMD17;
               cmd_d   = cmd_frame;
               cnt_d   = 16'd0;
            end else begin
               state_d = sCheckCount;
            end
         end
         sSendCMD17: begin
            // cmd_q[47] is the bit currently on MOSI
            cmd_d = {cmd_q[46:0], 1'b1};
            if (cnt_q == 16'd47) begin
               state_d     = sWaitR1;
               cnt_d       = 16'd0;
               r1_active_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         sWaitR1: begin
            if (r1_active_q) begin
               shreg_d = {shreg_q[6:0], MISO};
               if (cnt_q == 16'd7) begin
                  if ({shreg_q[6:0], MISO} == 8'h00) begin
                     state_d = sWaitToken;
                     cnt_d   = 16'd0;
                  end else begin
                     state_d = sERROR;
                  end
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end else if (!MISO) begin
               r1_active_d = 1'b1;
               shreg_d     = 8'h00;
               cnt_d       = 16'd1;
            end else if (cnt_q == R1_LAST) begin
               if (retry_q == RETRY_MAX) begin
                  state_d = sERROR;
               end else begin
                  retry_d = retry_q + 8'd1;
                  state_d = sSendCMD17;
                  cmd_d   = cmd_frame;
                  cnt_d   = 16'd0;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         sWaitToken: begin
            if (!MISO) begin
               state_d = sRecvData;
               cnt_d   = 16'd0;
            end else if (cnt_q == TOKEN_LAST) begin
               state_d = sERROR;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         sRecvData: begin
            shreg_d = {shreg_q[6:0], MISO};
            if (cnt_q[2:0] == 3'd7) begin
               push_d = 1'b1;
               data_d = {shreg_q[6:0], MISO};
            end else begin
               push_d = 1'b0;
            end
            if (cnt_q == 16'd4095) begin
               state_d = sRecvCRC;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         sRecvCRC: begin
            if (cnt_q == 16'd15) begin
               state_d = sNextBlock;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         sNextBlock: begin
            addr_d   = addr_q + 32'd1;
            blocks_d = blocks_q + 8'd1;
            retry_d  = 8'd0;
            state_d  = sCheckCount;
         end
         sFINAL:  state_d = sFINAL;
         sERROR:  state_d = sERROR;
         default: state_d = sERROR;
      endcase

      mosi_d  = (state_d == sSendCMD17) ? cmd_d[47] : 1'b1;
      busy_d  = !(state_d inside {sIdle, sFINAL, sERROR});
      error_d = (state_d == sERROR);
      led_d   = {state_d, 3'b111};
   end

   // State and registered-output flops.
   always_ff @(posedge i_s_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= sIdle;
         addr_q      <= START_ADDRESS;
         blocks_q    <= 8'd0;
         retry_q     <= 8'd0;
         cnt_q       <= 16'd0;
         cmd_q       <= 48'hFFFF_FFFF_FFFF;
         shreg_q     <= 8'd0;
         r1_active_q <= 1'b0;
         mosi_q      <= 1'b1;
         push_q      <= 1'b0;
         data_q      <= 8'd0;
         busy_q      <= 1'b0;
         error_q     <= 1'b0;
         led_q       <= 8'h07;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         blocks_q    <= blocks_d;
         retry_q     <= retry_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         shreg_q     <= shreg_d;
         r1_active_q <= r1_active_d;
         mosi_q      <= mosi_d;
         push_q      <= push_d;
         data_q      <= data_d;
         busy_q      <= busy_d;
         error_q     <= error_d;
         led_q       <= led_d;
      end
   end

   assign MOSI             = mosi_q;
   assign o_fifo_push      = push_q;
   assign o_8_fifo_data_in = data_q;
   assign o_busy           = busy_q;
   assign o_error          = error_q;
   assign o_8_LED          = led_q;

endmodule
